bus_arbiter: RTL and testbench

Three-master arbiter for the shared 16-bit-address/8-bit-data external memory bus. Requesters: VGA scan-out master (read-only), UART debug master, and Z80 CPU. It sequences one bus cycle at a time, multiplexes address, data, write-enable and chip-select onto the shared bus, and returns the slave acknowledge only to the granted master. A starvation counter guarantees the CPU forward progress under continuous high-priority traffic.

---
 rtl/bus_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - three-master arbiter for the shared external memory bus
//
// Masters, highest priority first: VGA scan-out (read only), UART debug, Z80 CPU.
// One bus cycle is run at a time. Each grant is followed by a one-cycle RELEASE
// gap. A saturating starvation counter lifts the CPU above both other masters
// once it has waited STARVE_MAX cycles.
//
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a GRANT with no slave
// ack for TIMEOUT cycles is force-acked and o_timeout pulses. When undefined,
// GRANT waits for i_ack indefinitely and o_timeout is tied to 0.
//
// Parameters
//   STARVE_MAX  cycles a pending CPU request may wait before it wins (1..15)
//   TIMEOUT     GRANT cycles without i_ack before forced termination (1..255)
// Ports
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_vga_cs, i_vga_addr, o_vga_ack     VGA read master
//   i_uart_cs/we/addr/dat, o_uart_ack   UART master
//   i_cpu_cs/we/addr/dat, o_cpu_ack     CPU master
//   o_addr, o_dat, o_we, o_cs           shared bus, driven only in GRANT
//   i_ack                               slave acknowledge
//   o_grant                             one-hot owner {cpu, uart, vga}, 0 when idle
//   o_timeout                           one-cycle pulse on forced termination

module bus_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_vga_cs,
    input  logic [15:0] i_vga_addr,
    output logic        o_vga_ack,
    input  logic        i_uart_cs,
    input  logic        i_uart_we,
    input  logic [15:0] i_uart_addr,
    input  logic [7:0]  i_uart_dat,
    output logic        o_uart_ack,
    input  logic        i_cpu_cs,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_dat,
    output logic        o_cpu_ack,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    output logic        o_we,
    output logic        o_cs,
    input  logic        i_ack,
    output logic [2:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  req;
    logic [2:0]  winner;
    logic        owner_cs;
    logic        force_ack;
    logic        ack_all;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tcnt_q, tcnt_d;
`endif

    assign req      = {i_cpu_cs, i_uart_cs, i_vga_cs};
    // Abort check: the granted master still holding its request.
    assign owner_cs = |(grant_q & req);

    // Fixed priority with the starvation override. The comparison is >= so
    // that a CPU whose counter passes the limit while another master is mid
    // transfer still wins the next arbitration.
    always_comb begin
        winner = 3'b000;
        if (i_cpu_cs && (starve_q >= STARVE_LIM)) begin
            winner = 3'b100;
        end else if (i_vga_cs) begin
            winner = 3'b001;
        end else if (i_uart_cs) begin
            winner = 3'b010;
        end else if (i_cpu_cs) begin
            winner = 3'b100;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        force_ack = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        case (state_q)
            IDLE, RELEASE: begin
                grant_d = winner;
                if (|winner) begin
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d  = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_cs || i_ack) begin
                    state_d = RELEASE;
                    grant_d = 3'b000;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (tcnt_q == TIMEOUT_LAST) begin
                        force_ack = 1'b1;
                        state_d   = RELEASE;
                        grant_d   = 3'b000;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    // The counter sees the current owner, so it stops climbing only once the
    // CPU actually holds the bus.
    always_comb begin
        starve_d = 4'd0;
        if (i_cpu_cs && !grant_q[2]) begin
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            grant_q  <= 3'b000;
            starve_q <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
`endif
        end
    end

    always_comb begin
        o_addr = 16'h0000;
        o_dat  = 8'h00;
        o_we   = 1'b0;
        o_cs   = 1'b0;
        if (state_q == GRANT) begin
            case (grant_q)
                3'b001: begin
                    o_addr = i_vga_addr;
                    o_cs   = i_vga_cs;
                end
                3'b010: begin
                    o_addr = i_uart_addr;
                    o_dat  = i_uart_dat;
                    o_we   = i_uart_we;
                    o_cs   = i_uart_cs;
                end
                3'b100: begin
                    o_addr = i_cpu_addr;
                    o_dat  = i_cpu_dat;
                    o_we   = i_cpu_we;
                    o_cs   = i_cpu_cs;
                end
                default: begin
                    o_cs = 1'b0;
                end
            endcase
        end
    end

    // Acks are gated by reset so a transfer cut short by reset is never acked.
    assign ack_all    = (state_q == GRANT) && owner_cs && (i_ack || force_ack) && !i_reset;
    assign o_vga_ack  = ack_all && grant_q[0];
    assign o_uart_ack = ack_all && grant_q[1];
    assign o_cpu_ack  = ack_all && grant_q[2];
    assign o_grant    = grant_q;

`ifdef ARB_TIMEOUT_EN
    assign o_timeout  = force_ack && !i_reset;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized bench for bus_arbiter against a bus-ownership model
module tb_bus_arbiter;

    localparam int STARVE_MAX = 8;
    localparam int TIMEOUT    = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_vga_cs;
    logic [15:0] i_vga_addr;
    logic        o_vga_ack;
    logic        i_uart_cs, i_uart_we;
    logic [15:0] i_uart_addr;
    logic [7:0]  i_uart_dat;
    logic        o_uart_ack;
    logic        i_cpu_cs, i_cpu_we;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_dat;
    logic        o_cpu_ack;
    logic [15:0] o_addr;
    logic [7:0]  o_dat;
    logic        o_we, o_cs;
    logic        i_ack;
    logic [2:0]  o_grant;
    logic        o_timeout;

    always #5 i_clk = ~i_clk;

    bus_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_vga_cs(i_vga_cs), .i_vga_addr(i_vga_addr), .o_vga_ack(o_vga_ack),
        .i_uart_cs(i_uart_cs), .i_uart_we(i_uart_we), .i_uart_addr(i_uart_addr),
        .i_uart_dat(i_uart_dat), .o_uart_ack(o_uart_ack),
        .i_cpu_cs(i_cpu_cs), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_dat(i_cpu_dat), .o_cpu_ack(o_cpu_ack),
        .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
        .i_ack(i_ack), .o_grant(o_grant), .o_timeout(o_timeout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 vga, 2 uart, 3 cpu), how long the
    // current owner has waited, and how long the CPU has been kept waiting.
    int         m_owner, m_wait, m_starve;
    logic [2:0] last_ack;

    // Observations collected per directed scenario.
    int         cyc, cs_cycles, to_count, first_cpu, first_to;
    int         ack_cnt [3];
    logic [2:0] obs_grant, prev_grant;
    logic [2:0] gseq [$];

    task automatic clear_obs();
        cyc = 0; cs_cycles = 0; to_count = 0; first_cpu = -1; first_to = -1;
        for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
        prev_grant = 3'b000;
        gseq.delete();
    endtask

    task automatic step();
        logic [2:0]  cs, eg, eack;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ew, ecs, own_cs, to;
        int          idx, nxt;
        @(negedge i_clk);
        cs = {i_cpu_cs, i_uart_cs, i_vga_cs};
        obs_grant = o_grant;
        if (o_cs) cs_cycles++;
        if (o_vga_ack)  ack_cnt[0]++;
        if (o_uart_ack) ack_cnt[1]++;
        if (o_cpu_ack)  ack_cnt[2]++;
        if (o_timeout) begin
            to_count++;
            if (first_to < 0) first_to = cyc;
        end
        if (o_grant != 3'b000 && o_grant != prev_grant) gseq.push_back(o_grant);
        prev_grant = o_grant;
        if (o_grant == 3'b100 && first_cpu < 0) first_cpu = cyc;

        if (i_reset) begin
            check("reset_acks", 32'({o_cpu_ack, o_uart_ack, o_vga_ack}), 0);
            check("reset_timeout", 32'(o_timeout), 0);
            m_owner = 0; m_wait = 0; m_starve = 0; last_ack = 3'b000;
        end else begin
            eg = 0; eack = 0; ea = 0; ed = 0; ew = 0; ecs = 0; to = 0; own_cs = 0; idx = 0;
            if (m_owner != 0) begin
                idx    = m_owner - 1;
                own_cs = cs[idx];
                eg     = 3'(1 << idx);
                ecs    = own_cs;
                if (idx == 0) begin
                    ea = i_vga_addr;
                end else if (idx == 1) begin
                    ea = i_uart_addr; ed = i_uart_dat; ew = i_uart_we;
                end else begin
                    ea = i_cpu_addr; ed = i_cpu_dat; ew = i_cpu_we;
                end
`ifdef ARB_TIMEOUT_EN
                to = own_cs && !i_ack && (m_wait == TIMEOUT - 1);
`endif
                if (own_cs && (i_ack || to)) eack = eg;
            end
            check("grant", 32'(o_grant), 32'(eg));
            check("bus_cs", 32'(o_cs), 32'(ecs));
            check("bus_addr", 32'(o_addr), 32'(ea));
            check("bus_dat", 32'(o_dat), 32'(ed));
            check("bus_we", 32'(o_we), 32'(ew));
            check("acks", 32'({o_cpu_ack, o_uart_ack, o_vga_ack}), 32'(eack));
            check("timeout", 32'(o_timeout), 32'(to));
            last_ack = eack;

            nxt = m_owner;
            if (m_owner != 0) begin
                if (!own_cs || i_ack || to) nxt = 0;
                else m_wait++;
            end else begin
                if (cs[2] && m_starve >= STARVE_MAX) nxt = 3;
                else if (cs[0]) nxt = 1;
                else if (cs[1]) nxt = 2;
                else if (cs[2]) nxt = 3;
                m_wait = 0;
            end
            if (cs[2] && m_owner != 3) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else m_starve = 0;
            m_owner = nxt;
        end
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_vga_cs = 0; i_vga_addr = 0;
        i_uart_cs = 0; i_uart_we = 0; i_uart_addr = 0; i_uart_dat = 0;
        i_cpu_cs = 0; i_cpu_we = 0; i_cpu_addr = 0; i_cpu_dat = 0;
        i_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1;
        step();
        step();
        i_reset = 0;
        step();
    endtask

    initial begin
        i_reset = 1;
        idle_inputs();
        last_ack = 0; m_owner = 0; m_wait = 0; m_starve = 0;
        clear_obs();
        @(posedge i_clk);
        #1;
        do_reset();
        check("reset_grant", 32'(obs_grant), 0);

        // Single CPU write with two wait states.
        clear_obs();
        i_cpu_we = 1; i_cpu_addr = 16'h1234; i_cpu_dat = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            i_cpu_cs = (i <= 3);
            i_ack    = (i == 3);
            step();
        end
        check("cpu_write_cs_cycles", cs_cycles, 3);
        check("cpu_write_acks", ack_cnt[2], 1);
        check("cpu_write_first_grant", first_cpu, 1);

        // All three request at once, zero-wait slave.
        do_reset();
        clear_obs();
        i_vga_cs = 1; i_vga_addr = 16'h8000;
        i_uart_cs = 1; i_uart_we = 1; i_uart_addr = 16'h0042; i_uart_dat = 8'h3C;
        i_cpu_cs = 1; i_cpu_we = 0; i_cpu_addr = 16'hBEEF; i_cpu_dat = 8'h11;
        i_ack = 1;
        for (int i = 0; i < 8; i++) begin
            if (last_ack[0]) i_vga_cs = 0;
            if (last_ack[1]) i_uart_cs = 0;
            if (last_ack[2]) i_cpu_cs = 0;
            step();
        end
        check("order_len", gseq.size(), 3);
        if (gseq.size() == 3) begin
            check("order_0", 32'(gseq[0]), 32'h1);
            check("order_1", 32'(gseq[1]), 32'h2);
            check("order_2", 32'(gseq[2]), 32'h4);
        end
        check("order_acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2], 3);

        // Continuous VGA traffic starving a pending CPU request.
        do_reset();
        clear_obs();
        i_vga_cs = 1; i_vga_addr = 16'h4000;
        i_cpu_cs = 1; i_cpu_addr = 16'h0100;
        i_ack = 1;
        for (int i = 0; i < 16; i++) begin
            if (last_ack[2]) i_cpu_cs = 0;
            step();
        end
        check("starve_first_cpu", first_cpu, 9);
        check("starve_seq_len_ok", 32'(gseq.size() >= 6), 1);
        if (gseq.size() >= 6) begin
            check("starve_cpu_slot", 32'(gseq[4]), 32'h4);
            check("starve_vga_resume", 32'(gseq[5]), 32'h1);
        end

        // UART aborts in its second GRANT cycle; CPU follows.
        do_reset();
        clear_obs();
        i_uart_addr = 16'h00AA; i_uart_dat = 8'h55; i_uart_we = 1;
        i_cpu_addr = 16'h2222;
        for (int i = 0; i < 7; i++) begin
            i_uart_cs = (i < 2);
            i_cpu_cs  = (i < 5);
            i_ack     = (i >= 4);
            step();
        end
        check("abort_uart_acks", ack_cnt[1], 0);
        check("abort_cpu_grant", first_cpu, 4);
        check("abort_cpu_acks", ack_cnt[2], 1);

        // Reset pulsed mid-GRANT while the slave acks.
        do_reset();
        clear_obs();
        i_cpu_cs = 1; i_cpu_addr = 16'h7777; i_cpu_we = 1; i_cpu_dat = 8'h99;
        for (int i = 0; i < 5; i++) begin
            i_reset = (i == 2);
            i_ack   = (i == 2);
            step();
            if (i == 3) check("rst_mid_released", 32'(obs_grant), 0);
            if (i == 4) check("rst_mid_regrant", 32'(obs_grant), 32'h4);
        end
        check("rst_mid_no_ack", ack_cnt[2], 0);

        // Slave never acks.
        do_reset();
        clear_obs();
        i_cpu_cs = 1; i_cpu_addr = 16'h0F0F;
        i_ack = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 20; i++) step();
        check("timeout_cycle", first_to, TIMEOUT);
        check("timeout_pulses", to_count, 1);
        check("timeout_acks", ack_cnt[2], 1);
`else
        for (int i = 0; i < 1000; i++) step();
        check("hold_grant", 32'(obs_grant), 32'h4);
        check("hold_no_ack", ack_cnt[2], 0);
        check("hold_no_timeout", to_count, 0);
`endif

        // Randomized traffic against the model.
        do_reset();
        clear_obs();
        for (int n = 0; n < 3000; n++) begin
            i_reset = ($urandom_range(0, 599) == 0);
            if (last_ack[0] || !i_vga_cs) begin
                i_vga_cs   = ($urandom_range(0, 2) != 0);
                i_vga_addr = 16'($urandom);
            end
            if (last_ack[1] || !i_uart_cs) begin
                i_uart_cs   = ($urandom_range(0, 1) == 1);
                i_uart_we   = 1'($urandom);
                i_uart_addr = 16'($urandom);
                i_uart_dat  = 8'($urandom);
            end
            if (last_ack[2] || !i_cpu_cs) begin
                i_cpu_cs   = ($urandom_range(0, 1) == 1);
                i_cpu_we   = 1'($urandom);
                i_cpu_addr = 16'($urandom);
                i_cpu_dat  = 8'($urandom);
            end
            if (m_owner == 1 && $urandom_range(0, 15) == 0) i_vga_cs = 0;
            if (m_owner == 2 && $urandom_range(0, 15) == 0) i_uart_cs = 0;
            if (m_owner == 3 && $urandom_range(0, 15) == 0) i_cpu_cs = 0;
            i_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        check("random_cpu_served", 32'(ack_cnt[2] > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
